// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply / restoring-divide sequencer with HI/LO result registers.
// busy_o stalls the pipeline while an operation is in flight; done_o pulses when HI/LO update.
module muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              dbz_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    logic [1:0]          r_state;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W:0]     r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_div;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_dbz;

    logic                w_accept;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]     w_rem_sh;
    logic                w_ge;
    logic [DATA_W:0]     w_rem_nx;
    logic [DATA_W-1:0]   w_quo_nx;

    assign w_accept = start_i && (op_i == OP_MULTU || op_i == OP_DIVU) &&
                      (r_state == S_IDLE || r_state == S_DONE);

    assign w_prod = {{DATA_W{1'b0}}, src1_i} * {{DATA_W{1'b0}}, src2_i};

    // One restoring step; r_rem's top bit stands in for the bit shifted out of the remainder.
    always_comb begin
        w_rem_sh = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
        w_ge     = r_rem[DATA_W] || (w_rem_sh >= {1'b0, r_div});
        w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
        w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_dbz <= 1'b0;
                        if (op_i == OP_MULTU) begin
                            r_prod  <= w_prod;
                            r_state <= S_MULT;
                        end else begin
                            r_div   <= src2_i;
                            r_quo   <= src1_i;
                            r_rem   <= '0;
                            r_cnt   <= CNT_W'(DATA_W);
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MULT: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        {r_hi, r_lo} <= r_prod;
                        r_state      <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_div == '0) begin
                        // Dividend is still parked in r_quo, untouched by any iteration.
                        r_hi    <= r_quo;
                        r_lo    <= '1;
                        r_dbz   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_hi    <= w_rem_nx[DATA_W-1:0];
                            r_lo    <= w_quo_nx;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state == S_MULT) || (r_state == S_DIV);
    assign done_o = (r_state == S_DONE);
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign dbz_o  = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against plain-arithmetic expectations.
module tb_muldiv_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        dbz_o;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .op_i   (op_i),
        .src1_i (src1_i),
        .src2_i (src2_i),
        .flush_i(flush_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .hi_o   (hi_o),
        .lo_o   (lo_o),
        .dbz_o  (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: results from ordinary arithmetic, timing from the documented latencies.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edbz,
                         output int elat, output int ebusy);
        logic [63:0] p;
        if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            eh = p[63:32]; el = p[31:0]; edbz = 1'b0; elat = 2; ebusy = 1;
        end else if (b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF; edbz = 1'b1; elat = 2; ebusy = 1;
        end else begin
            eh = a % b; el = a / b; edbz = 1'b0; elat = 33; ebusy = 32;
        end
    endtask

    // Presents start in the current cycle, then follows the op to its done cycle and stops there.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic fl);
        logic [31:0] eh, el;
        logic        edbz;
        int          elat, ebusy, lat, nb;
        model(op, a, b, eh, el, edbz, elat, ebusy);
        start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; flush_i = fl;
        tick();
        start_i = 1'b0; op_i = 2'b00; flush_i = 1'b0;
        src1_i = $urandom; src2_i = $urandom;
        chk("dbz_clear_on_accept", 64'(dbz_o), 64'd0);
        lat = 1; nb = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) nb++;
            tick();
            lat++;
        end
        chk("done_latency", 64'(lat), 64'(elat));
        chk("busy_cycles", 64'(nb), 64'(ebusy));
        chk("busy_low_at_done", 64'(busy_o), 64'd0);
        chk("hi", 64'(hi_o), 64'(eh));
        chk("lo", 64'(lo_o), 64'(el));
        chk("dbz", 64'(dbz_o), 64'(edbz));
    endtask

    initial begin
        int ndone;
        rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; src1_i = '0; src2_i = '0; flush_i = 1'b0;
        tick();
        tick();
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_dbz", 64'(dbz_o), 64'd0);
        rst_i = 1'b1;
        tick();

        // op 00 ignored
        start_i = 1'b1; op_i = 2'b00; src1_i = 32'd5; src2_i = 32'd6;
        tick();
        start_i = 1'b0;
        chk("op00_busy", 64'(busy_o), 64'd0);
        chk("op00_done", 64'(done_o), 64'd0);
        tick();
        chk("op00_done2", 64'(done_o), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        tick();
        chk("done_one_cycle", 64'(done_o), 64'd0);
        run_op(2'b10, 32'd100, 32'd7, 1'b0);
        tick();
        run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        run_op(2'b10, 32'd55, 32'd0, 1'b0);
        tick();
        chk("dbz_sticky", 64'(dbz_o), 64'd1);
        run_op(2'b01, 32'd3, 32'd3, 1'b0);
        tick();

        // Flush mid-divide with an ignored start in between
        start_i = 1'b1; op_i = 2'b10; src1_i = 32'd100; src2_i = 32'd7;
        tick();
        start_i = 1'b0; op_i = 2'b00;
        repeat (4) tick();
        start_i = 1'b1; op_i = 2'b01; src1_i = 32'd5; src2_i = 32'd5;
        tick();
        start_i = 1'b0; op_i = 2'b00;
        chk("ignored_start_busy", 64'(busy_o), 64'd1);
        repeat (4) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_hi", 64'(hi_o), 64'd0);
        chk("flush_lo", 64'(lo_o), 64'd9);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) ndone++;
            tick();
        end
        chk("flush_quiet", 64'(ndone), 64'd0);

        // Back-to-back: DIVU accepted in the MULTU done cycle
        run_op(2'b01, 32'd6, 32'd7, 1'b0);
        run_op(2'b10, 32'd9, 32'd2, 1'b0);
        tick();

        // Reset mid-divide
        start_i = 1'b1; op_i = 2'b10; src1_i = 32'd1000; src2_i = 32'd3;
        tick();
        start_i = 1'b0; op_i = 2'b00;
        repeat (10) tick();
        rst_i = 1'b0;
        tick();
        chk("midrst_hi", 64'(hi_o), 64'd0);
        chk("midrst_lo", 64'(lo_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_dbz", 64'(dbz_o), 64'd0);
        rst_i = 1'b1;
        tick();

        // Randomized operations, sometimes back-to-back, sometimes with a coincident flush
        for (int i = 0; i < 14; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            int          sel;
            rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk("rnd_done_one_cycle", 64'(done_o), 64'd0);
            end
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reserved op in DONE is ignored and the FSM drops to idle
        start_i = 1'b1; op_i = 2'b11;
        tick();
        start_i = 1'b0; op_i = 2'b00;
        chk("op11_busy", 64'(busy_o), 64'd0);
        chk("op11_done", 64'(done_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
